// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state encoding and parity selection
package uart_pkg;
  localparam int DBIT_DEF = 8;
  localparam int OS_DEF = 16;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  typedef enum logic {PAR_EVEN = 1'b0, PAR_ODD = 1'b1} parity_t;
  localparam parity_t PARITY_TYPE = PAR_EVEN;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an async input, resets to 1 (idle line level)
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8-N-1 UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8-E-1 frames and report parity errors.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DBIT = DBIT_DEF,
  parameter int OS = OS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            tick,
  output logic [DBIT-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun
);
  localparam int SW = $clog2(OS);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_MID = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OS - 1);
  localparam logic [NW-1:0] N_END = NW'(DBIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic par_q, par_d;
  logic rx_s, rx_q;
  logic stop_hit, deliver;
  uart_sync2 u_sync (
    .clk(clk),
    .reset(reset),
    .d(rx),
    .q(rx_s)
  );
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    n_d = n_q;
    b_d = b_q;
    par_d = par_q;
    stop_hit = 1'b0;
    unique case (state_q)
      IDLE:
        if (!rx_s && rx_q) begin
          state_d = START;
          s_d = '0;
        end
      START:
        if (tick) begin
          if (s_q == S_MID) begin
            state_d = rx_s ? IDLE : DATA;
            s_d = '0;
            n_d = '0;
            par_d = 1'b0;
          end else s_d = s_q + SW'(1);
        end
      DATA:
        if (tick) begin
          if (s_q == S_END) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            n_d = n_q + NW'(1);
            state_d = (n_q == N_END) ? AFTER_DATA : DATA;
          end else s_d = s_q + SW'(1);
        end
`ifdef UART_RX_PARITY_EN
      PARITY:
        if (tick) begin
          if (s_q == S_END) begin
            par_d = (^b_q) ^ rx_s ^ (PARITY_TYPE == PAR_ODD);
            s_d = '0;
            state_d = STOP;
          end else s_d = s_q + SW'(1);
        end
`endif
      STOP:
        if (tick) begin
          if (s_q == S_END) begin
            state_d = IDLE;
            s_d = '0;
            stop_hit = 1'b1;
          end else s_d = s_q + SW'(1);
        end
      default: state_d = IDLE;
    endcase
  end
  // par_q holds "parity bad" for the frame in flight; it stays 0 when parity is compiled out
  assign deliver = stop_hit && rx_s && !par_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      s_q <= '0;
      n_q <= '0;
      b_q <= '0;
      par_q <= 1'b0;
      rx_q <= 1'b1;
      dout <= '0;
      dout_valid <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      n_q <= n_d;
      b_q <= b_d;
      par_q <= par_d;
      rx_q <= rx_s;
      frame_err <= stop_hit && !rx_s;
      parity_err <= stop_hit && par_q;
      overrun <= deliver && dout_valid && !dout_ready;
      if (deliver && (!dout_valid || dout_ready)) begin
        dout <= b_q;
        dout_valid <= 1'b1;
      end else if (dout_ready) dout_valid <= 1'b0;
    end
endmodule
